// File: rtl/bcd_conv_sched_pkg.sv
// rtl/bcd_conv_sched_pkg.sv - shared types and helpers for the shared BCD conversion engine
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_e;

    // Number of decimal digits needed to hold the largest unsigned value of the given width
    function automatic int bcd_digits_needed(input int width);
        longint unsigned max_val;
        longint unsigned pow;
        int              n;
        max_val = (64'd1 << width) - 64'd1;
        pow     = 64'd10;
        n       = 1;
        for (int i = 0; i < 20; i++) begin
            if (pow <= max_val) begin
                pow = pow * 64'd10;
                n   = n + 1;
            end
        end
        return n;
    endfunction

    // Double-dabble correction: a digit that would reach 10 or more after the shift gets +3 first
    function automatic bcd_digit_t add3_digit(input bcd_digit_t d);
        return (d >= 4'd5) ? bcd_digit_t'(d + 4'd3) : d;
    endfunction

endpackage

// File: rtl/bcd_conv_sched_if.sv
// rtl/bcd_conv_sched_if.sv - requester and response bundle of the shared BCD engine
interface bcd_conv_sched_if
    import bcd_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int BIN_W   = 8,
    parameter int DIGITS  = 3
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*BIN_W-1:0]   req_bin;
    logic [NUM_REQ-1:0]         req_ready;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [BCD_DIGIT_W*DIGITS-1:0] rsp_bcd;
    logic [ID_W-1:0]            rsp_id;
    logic                       busy;

    modport master (
        output req_valid, req_bin, rsp_ready,
        input  req_ready, rsp_valid, rsp_bcd, rsp_id, busy
    );

    modport slave (
        input  req_valid, req_bin, rsp_ready,
        output req_ready, rsp_valid, rsp_bcd, rsp_id, busy
    );

endinterface

// File: rtl/bcd_conv_sched_arbiter.sv
// rtl/bcd_conv_sched_arbiter.sv - round-robin one-hot grant starting at a rotating pointer
module bcd_rr_arbiter
    import bcd_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    idx_o
);

    logic [ID_W:0]   cand;
    logic [ID_W-1:0] cand_idx;
    logic            found;

    // Scan requesters from the pointer upward with wraparound; first valid one wins
    always_comb begin
        gnt_o    = '0;
        idx_o    = '0;
        found    = 1'b0;
        cand     = '0;
        cand_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_i} + (ID_W+1)'(i);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            cand_idx = cand[ID_W-1:0];
            if (en_i && !found && req_i[cand_idx]) begin
                gnt_o[cand_idx] = 1'b1;
                idx_o           = cand_idx;
                found           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_conv_sched.sv
// rtl/bcd_conv_sched.sv - shared sequential double-dabble converter with round-robin request arbitration
module bcd_conv_sched
    import bcd_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int BIN_W   = 8,
    parameter int DIGITS  = 3
) (
    input  logic           clk,
    input  logic           rst,
    bcd_conv_sched_if.slave bus
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CAT_W = BCD_W + BIN_W;

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_SHIFT = SHIFT;
    localparam logic [1:0] ST_DONE  = DONE;

    generate
        if (DIGITS < bcd_digits_needed(BIN_W) || NUM_REQ < 2 || NUM_REQ > 8 || BIN_W < 1 || BIN_W > 16) begin : g_param_check
            $error("bcd_conv_sched: illegal NUM_REQ/BIN_W/DIGITS combination");
        end
    endgenerate

    logic [1:0]       state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [BCD_W-1:0] rsp_bcd_q, rsp_bcd_d;
    logic             rsp_valid_q, rsp_valid_d;

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               arb_en;
    logic [BIN_W-1:0]   op_sel;
    logic [BCD_W-1:0]   bcd_adj;
    logic [CAT_W-1:0]   cat_sh;

    // Grants are only offered while idle and never while reset is held
    assign arb_en = (state_q == ST_IDLE) && !rst;

    bcd_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_i (bus.req_valid),
        .ptr_i (ptr_q),
        .en_i  (arb_en),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    assign op_sel = bus.req_bin[gnt_idx*BIN_W +: BIN_W];

    // One double-dabble step: correct every digit in parallel, then shift the combined register left
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            bcd_adj[i*BCD_DIGIT_W +: BCD_DIGIT_W] = add3_digit(bcd_q[i*BCD_DIGIT_W +: BCD_DIGIT_W]);
        end
        cat_sh = {bcd_adj, bin_q} << 1;
    end

    // Conversion FSM: accept in IDLE, BIN_W steps in SHIFT, hold the result in DONE until taken
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        rsp_bcd_d   = rsp_bcd_q;
        rsp_valid_d = rsp_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (|gnt) begin
                    bin_d   = op_sel;
                    bcd_d   = '0;
                    id_d    = gnt_idx;
                    ptr_d   = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + ID_W'(1);
                    cnt_d   = CNT_W'(BIN_W);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bcd_d = cat_sh[CAT_W-1 -: BCD_W];
                bin_d = cat_sh[BIN_W-1:0];
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = ST_DONE;
                    rsp_valid_d = 1'b1;
                    rsp_bcd_d   = cat_sh[CAT_W-1 -: BCD_W];
                end
            end
            ST_DONE: begin
                if (bus.rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any conversion in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            cnt_q       <= '0;
            bin_q       <= '0;
            bcd_q       <= '0;
            rsp_bcd_q   <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            rsp_bcd_q   <= rsp_bcd_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign bus.req_ready = gnt;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_bcd   = rsp_bcd_q;
    assign bus.rsp_id    = id_q;
    assign bus.busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);

endmodule

// File: tb/tb_bcd_conv_sched.sv
// tb/tb_bcd_conv_sched.sv - directed scoreboard bench for the shared BCD converter
module tb_bcd_conv_sched;

    localparam int NR   = 4;
    localparam int BW   = 8;
    localparam int DG   = 3;
    localparam int ID_W = $clog2(NR);

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [4*DG-1:0] bcd;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    bcd_conv_sched_if #(.NUM_REQ(NR), .BIN_W(BW), .DIGITS(DG)) bif ();

    bcd_conv_sched #(.NUM_REQ(NR), .BIN_W(BW), .DIGITS(DG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_acc = 0;
    logic prev_rv = 1'b0;
    exp_t exp_q[$];
    int   acc_id_q[$];
    int   acc_edge_q[$];

    function automatic logic [4*DG-1:0] to_bcd(input int v);
        logic [4*DG-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < DG; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic issue(input int k, input int val);
        exp_t e;
        logic [31:0] v32;
        v32 = 32'(val);
        bif.req_bin[k*BW +: BW] = v32[BW-1:0];
        bif.req_valid[k] = 1'b1;
        e.id  = ID_W'(k);
        e.bcd = to_bcd(val);
        exp_q.push_back(e);
    endtask

    // Sample at the falling edge, step past the rising edge, retire accepted requests
    task automatic tick();
        logic [NR-1:0] hs;
        exp_t e;
        @(negedge clk);
        hs = bif.req_valid & bif.req_ready;
        for (int k = 0; k < NR; k++) begin
            if (hs[k]) begin
                acc_id_q.push_back(k);
                acc_edge_q.push_back(cyc + 1);
                last_acc = cyc + 1;
            end
        end
        if (bif.rsp_valid && !prev_rv) begin
            chk("latency", 32'(cyc - last_acc), 32'(BW));
        end
        prev_rv = bif.rsp_valid;
        if (bif.rsp_valid && bif.rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 32'(bif.rsp_id), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_id", 32'(bif.rsp_id), 32'(e.id));
                chk("rsp_bcd", 32'(bif.rsp_bcd), 32'(e.bcd));
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        bif.req_valid = bif.req_valid & ~hs;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && (exp_q.size() != 0 || bif.req_valid != '0 || bif.busy); i++) begin
            tick();
        end
        chk("drain_done", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_acc(input int n);
        for (int i = 0; i < 60 && acc_id_q.size() < n; i++) begin
            tick();
        end
        chk("acc_wait", 32'(acc_id_q.size() >= n), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bif.req_valid = '0;
        bif.req_bin   = '0;
        bif.rsp_ready = 1'b1;

        // all four requesters valid from reset
        issue(0, 5);
        issue(1, 99);
        issue(2, 200);
        issue(3, 255);
        tick();
        tick();
        chk("rst_rsp_valid", 32'(bif.rsp_valid), 32'd0);
        chk("rst_rsp_bcd",   32'(bif.rsp_bcd),   32'd0);
        chk("rst_rsp_id",    32'(bif.rsp_id),    32'd0);
        chk("rst_busy",      32'(bif.busy),      32'd0);
        chk("rst_req_ready", 32'(bif.req_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("first_grant", 32'(bif.req_ready), 32'b0001);
        drain();
        chk("rr4_count", 32'(acc_id_q.size()), 32'd4);
        if (acc_id_q.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("rr4_order", 32'(acc_id_q[i]), 32'(i));
            for (int i = 0; i < 3; i++) chk("rr4_spacing", 32'(acc_edge_q[i+1] - acc_edge_q[i]), 32'(BW + 2));
        end
        acc_id_q.delete();
        acc_edge_q.delete();

        // single requester, same-cycle grant
        issue(0, 173);
        #1;
        chk("single_grant", 32'(bif.req_ready), 32'b0001);
        drain();

        // requesters 1 and 3 alternate
        acc_id_q.delete();
        issue(1, 10);
        issue(3, 42);
        wait_acc(1);
        issue(1, 77);
        wait_acc(2);
        issue(3, 128);
        drain();
        chk("alt_count", 32'(acc_id_q.size()), 32'd4);
        if (acc_id_q.size() == 4) begin
            chk("alt_0", 32'(acc_id_q[0]), 32'd1);
            chk("alt_1", 32'(acc_id_q[1]), 32'd3);
            chk("alt_2", 32'(acc_id_q[2]), 32'd1);
            chk("alt_3", 32'(acc_id_q[3]), 32'd3);
        end

        // consumer stalls in DONE
        acc_id_q.delete();
        bif.rsp_ready = 1'b0;
        issue(2, 64);
        for (int i = 0; i < 40 && !bif.rsp_valid; i++) tick();
        chk("stall_reached", 32'(bif.rsp_valid), 32'd1);
        issue(0, 1);
        for (int i = 0; i < 20; i++) begin
            chk("stall_valid", 32'(bif.rsp_valid), 32'd1);
            chk("stall_bcd",   32'(bif.rsp_bcd),   32'h064);
            chk("stall_id",    32'(bif.rsp_id),    32'd2);
            chk("stall_ready", 32'(bif.req_ready), 32'd0);
            tick();
        end
        chk("stall_no_accept", 32'(acc_id_q.size()), 32'd1);
        bif.rsp_ready = 1'b1;
        drain();
        chk("stall_after", 32'(acc_id_q.size()), 32'd2);
        if (acc_id_q.size() == 2) chk("stall_next_id", 32'(acc_id_q[1]), 32'd0);

        // every operand through requester 2
        for (int v = 0; v < 256; v++) begin
            issue(2, v);
            drain();
        end

        // reset in the middle of a conversion
        acc_id_q.delete();
        bif.req_bin[1*BW +: BW] = 8'd99;
        bif.req_valid[1] = 1'b1;
        wait_acc(1);
        if (acc_id_q.size() >= 1) chk("abort_grant", 32'(acc_id_q[0]), 32'd1);
        tick();
        tick();
        tick();
        tick();
        #2;
        rst = 1'b1;
        issue(0, 7);
        issue(2, 250);
        #1;
        chk("arst_rsp_valid", 32'(bif.rsp_valid), 32'd0);
        chk("arst_rsp_bcd",   32'(bif.rsp_bcd),   32'd0);
        chk("arst_rsp_id",    32'(bif.rsp_id),    32'd0);
        chk("arst_busy",      32'(bif.busy),      32'd0);
        chk("arst_req_ready", 32'(bif.req_ready), 32'd0);
        tick();
        rst = 1'b0;
        acc_id_q.delete();
        #1;
        chk("post_rst_grant", 32'(bif.req_ready), 32'b0001);
        drain();
        chk("post_rst_count", 32'(acc_id_q.size()), 32'd2);
        if (acc_id_q.size() == 2) begin
            chk("post_rst_0", 32'(acc_id_q[0]), 32'd0);
            chk("post_rst_1", 32'(acc_id_q[1]), 32'd2);
        end
        for (int i = 0; i < 12; i++) begin
            chk("no_late_rsp", 32'(bif.rsp_valid), 32'd0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_conv_sched.md
Name: bcd_conv_sched

Overview:
- Shares one sequential double-dabble binary-to-BCD engine among NUM_REQ requesters.
- A round-robin arbiter grants one request at a time. The engine converts the operand at one bit per clock, then presents the packed BCD result with the winning requester's index on a single valid/ready response port.
- Sits between the display/report clients and the BCD formatting path; it replaces per-client combinational converters.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- BIN_W, 8, binary operand width (1..16).
- DIGITS, 3, BCD digits in result. Elaboration error unless 10**DIGITS > 2**BIN_W-1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_bin  in  NUM_REQ*BIN_W  operands; requester k uses slice [k*BIN_W +: BIN_W].
- req_ready  out  NUM_REQ  one-hot grant/accept; handshake when req_valid[k]&req_ready[k].
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result consumer ready.
- rsp_bcd  out  4*DIGITS  packed BCD, digit 0 (ones) in [3:0].
- rsp_id  out  $clog2(NUM_REQ)  index of requester that owns rsp_bcd.
- busy  out  1  high in SHIFT or DONE.

Behaviour:
- Reset values: state IDLE, rsp_valid 0, rsp_bcd 0, rsp_id 0, busy 0, rr pointer 0, req_ready 0.
- Reset asserted mid-conversion aborts the conversion. No response is produced and the request is lost.
- IDLE:
  - req_ready is combinational: one-hot on the first valid requester at or after the rr pointer (wrapping), zero if none valid.
  - Requesters must not make req_valid depend on req_ready.
  - On handshake: capture operand into shift register, clear BCD accumulator, rsp_id <= winner, pointer <= (winner+1) mod NUM_REQ, count <= BIN_W, go to SHIFT.
- SHIFT, one step per clock:
  - Every digit >= 5 gets +3, all digits in parallel.
  - Then shift {bcd, operand} left by 1; operand MSB enters digit 0 bit 0.
  - count decrements. When count reaches 0 after the step, go to DONE with rsp_valid 1.
- Latency: rsp_valid rises exactly BIN_W clocks after the accepting edge.
- DONE:
  - rsp_valid held high; rsp_bcd and rsp_id stable until rsp_ready.
  - On rsp_valid&rsp_ready, go to IDLE and drop rsp_valid the next cycle. rsp_bcd keeps its last value.
- req_ready is 0 in SHIFT and DONE. Requests are held off, never dropped; requesters must keep req_valid and req_bin stable until accepted.
- Throughput: one conversion per BIN_W+2 cycles with an always-ready consumer (one IDLE arbitration cycle).
- Simultaneous requests: the pointer guarantees each persistently-valid requester is granted within NUM_REQ conversions.
- A requester dropping req_valid before grant is legal; it is simply not granted.
- The top digit never exceeds 9 under the DIGITS constraint; no overflow flag.
- Operand 0 yields all-zero BCD. Operand 2**BIN_W-1 converts correctly (e.g. 255 -> 0x255).

Decomposition:
- Package bcd_pkg:
  - BCD_DIGIT_W = 4
  - typedef bcd_digit_t (logic [3:0])
  - enum conv_state_e {IDLE, SHIFT, DONE}
  - function bcd_digits_needed(width) for the elaboration check
  - function add3_digit for the per-digit correction
- Sub-module bcd_rr_arbiter (NUM_REQ): inputs req vector, pointer, enable; outputs one-hot grant and encoded index.
- The datapath and FSM stay in bcd_conv_sched.

Test Plan:
- Single requester 0 sends 8'd173 with rsp_ready=1 -> req_ready[0] in the same cycle; rsp_valid exactly 8 clocks after acceptance; rsp_bcd=12'h173, rsp_id=0.
- Requesters 0..3 all valid from reset with operands 5,99,200,255 -> grants in order 0,1,2,3; results 0x005, 0x099, 0x200, 0x255; 10-cycle spacing.
- Requesters 1 and 3 persistently valid after a grant to 1 -> next grant 3, then 1; no requester is granted twice in a row while another waits.
- rsp_ready held low 20 cycles in DONE -> rsp_valid, rsp_bcd, rsp_id stable; req_ready all 0; no new acceptance until the response handshake.
- Exhaustive sweep of operands 0..255 via requester 2 -> rsp_bcd equals {v/100, (v/10)%10, v%10} for every v.
- Assert rst for 1 cycle at SHIFT step 4 -> all outputs at reset values immediately; no rsp_valid follows; next grant goes to requester 0.
